// File: rtl/axi_eth_tx_arb_pkg.sv
// Shared Ethernet TX constants and the header byte-select helper.
package axi_eth_tx_arb_pkg;

  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam int          ETH_HDR_LEN    = 14;
  localparam int          ETH_MIN_FRAME  = 60;
  localparam int          CNT_W          = 11;

  // Header is {dst(6), src(6), ethertype(2)}, emitted MSB first.
  function automatic logic [7:0] hdr_byte(input logic [111:0] hdr, input logic [3:0] idx);
    return hdr[8*(ETH_HDR_LEN-1-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/axi_eth_tx_arb.sv
// Round-robin ARP/IPv4 TX arbiter that frames the granted payload with an
// Ethernet header and zero-pads short frames to the minimum length.
module axi_eth_tx_arb
  import axi_eth_tx_arb_pkg::*;
#(
  parameter logic [23:0] MAC_MSB   = 24'h010203,
  parameter logic [23:0] MAC_LSB   = 24'h040506,
  parameter int          MIN_FRAME = ETH_MIN_FRAME
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  arp_axis_tdata,
  input  logic        arp_axis_tvalid,
  input  logic        arp_axis_tlast,
  output logic        arp_axis_tready,
  input  logic [47:0] arp_dst_mac,
  input  logic [7:0]  ip_axis_tdata,
  input  logic        ip_axis_tvalid,
  input  logic        ip_axis_tlast,
  output logic        ip_axis_tready,
  input  logic [47:0] ip_dst_mac,
  output logic [7:0]  mac_axis_tdata,
  output logic        mac_axis_tvalid,
  output logic        mac_axis_tlast,
  input  logic        mac_axis_tready,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_PAD} state_t;

  typedef struct packed {
    state_t           state;
    logic [3:0]       index;
    logic [CNT_W-1:0] count;
    logic             grant;
    logic             last_grant;
    logic [47:0]      dst_mac;
    logic [15:0]      ethertype;
  } reg_t;

  localparam logic GNT_ARP = 1'b0;
  localparam logic GNT_IP  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] PAD_LAST  = CNT_W'(MIN_FRAME - 1);
  localparam logic [CNT_W:0]   MIN_WIDE  = (CNT_W+1)'(MIN_FRAME);

  // last_grant resets to IP so that ARP wins the first simultaneous request.
  localparam reg_t R_RST = '{
    state:      S_IDLE,
    index:      4'd0,
    count:      '0,
    grant:      GNT_ARP,
    last_grant: GNT_IP,
    dst_mac:    48'd0,
    ethertype:  16'd0
  };

  reg_t r_reg;
  reg_t w_next;

  logic             w_src_valid;
  logic [7:0]       w_src_data;
  logic             w_src_last;
  logic             w_pick;
  logic             w_long_enough;
  logic [CNT_W-1:0] w_count_inc;
  logic [111:0]     w_hdr;

  // Granted-source view used by the payload pass-through.
  assign w_src_valid = (r_reg.grant == GNT_IP) ? ip_axis_tvalid : arp_axis_tvalid;
  assign w_src_data  = (r_reg.grant == GNT_IP) ? ip_axis_tdata  : arp_axis_tdata;
  assign w_src_last  = (r_reg.grant == GNT_IP) ? ip_axis_tlast  : arp_axis_tlast;

  // Round-robin on a tie, otherwise whichever single source is requesting.
  assign w_pick = (arp_axis_tvalid && ip_axis_tvalid) ? ~r_reg.last_grant
                : (ip_axis_tvalid ? GNT_IP : GNT_ARP);

  // True when the byte being accepted now brings the frame to minimum size.
  assign w_long_enough = ({1'b0, r_reg.count} + (CNT_W+1)'(1)) >= MIN_WIDE;
  assign w_count_inc   = (r_reg.count == CNT_MAX) ? CNT_MAX : r_reg.count + 1'b1;
  assign w_hdr         = {r_reg.dst_mac, MAC_MSB, MAC_LSB, r_reg.ethertype};

  // State register with synchronous reset override.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg <= R_RST;
    end else begin
      r_reg <= w_next;
    end
  end

  // Next-state: arbitration, header index, byte count and frame sequencing.
  always_comb begin
    w_next = r_reg;
    case (r_reg.state)
      S_IDLE: begin
        if (arp_axis_tvalid || ip_axis_tvalid) begin
          w_next.grant      = w_pick;
          w_next.last_grant = w_pick;
          w_next.dst_mac    = (w_pick == GNT_IP) ? ip_dst_mac : arp_dst_mac;
          w_next.ethertype  = (w_pick == GNT_IP) ? ETHERTYPE_IPV4 : ETHERTYPE_ARP;
          w_next.index      = 4'd0;
          w_next.count      = '0;
          w_next.state      = S_HEADER;
        end
      end
      S_HEADER: begin
        if (mac_axis_tready) begin
          w_next.index = r_reg.index + 4'd1;
          w_next.count = w_count_inc;
          if (r_reg.index == 4'(ETH_HDR_LEN - 1)) begin
            w_next.state = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (w_src_valid && mac_axis_tready) begin
          w_next.count = w_count_inc;
          if (w_src_last) begin
            w_next.state = w_long_enough ? S_IDLE : S_PAD;
          end
        end
      end
      S_PAD: begin
        if (mac_axis_tready) begin
          w_next.count = w_count_inc;
          if (r_reg.count >= PAD_LAST) begin
            w_next.state = S_IDLE;
          end
        end
      end
      default: w_next = R_RST;
    endcase
  end

  // Outputs: header/pad come from registered state, payload is a pass-through.
  always_comb begin
    mac_axis_tdata  = 8'h00;
    mac_axis_tvalid = 1'b0;
    mac_axis_tlast  = 1'b0;
    arp_axis_tready = 1'b0;
    ip_axis_tready  = 1'b0;
    busy            = (r_reg.state != S_IDLE);
    case (r_reg.state)
      S_HEADER: begin
        mac_axis_tvalid = 1'b1;
        mac_axis_tdata  = hdr_byte(w_hdr, r_reg.index);
      end
      S_PAYLOAD: begin
        mac_axis_tvalid = w_src_valid;
        mac_axis_tdata  = w_src_data;
        mac_axis_tlast  = w_src_valid && w_src_last && w_long_enough;
        arp_axis_tready = (r_reg.grant == GNT_ARP) && mac_axis_tready;
        ip_axis_tready  = (r_reg.grant == GNT_IP) && mac_axis_tready;
      end
      S_PAD: begin
        mac_axis_tvalid = 1'b1;
        mac_axis_tlast  = (r_reg.count >= PAD_LAST);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_eth_tx_arb.sv
// Scoreboard bench for axi_eth_tx_arb: expected frames are queued up front,
// a negedge monitor pops and compares every byte the MAC accepts.
module tb_axi_eth_tx_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  arp_tdata, ip_tdata;
  logic        arp_tvalid, arp_tlast, arp_tready;
  logic        ip_tvalid, ip_tlast, ip_tready;
  logic [47:0] arp_dst, ip_dst;
  logic [7:0]  mac_tdata;
  logic        mac_tvalid, mac_tlast, mac_tready;
  logic        busy;

  always #5 clk = ~clk;

  axi_eth_tx_arb dut (
    .clk             (clk),
    .reset           (reset),
    .arp_axis_tdata  (arp_tdata),
    .arp_axis_tvalid (arp_tvalid),
    .arp_axis_tlast  (arp_tlast),
    .arp_axis_tready (arp_tready),
    .arp_dst_mac     (arp_dst),
    .ip_axis_tdata   (ip_tdata),
    .ip_axis_tvalid  (ip_tvalid),
    .ip_axis_tlast   (ip_tlast),
    .ip_axis_tready  (ip_tready),
    .ip_dst_mac      (ip_dst),
    .mac_axis_tdata  (mac_tdata),
    .mac_axis_tvalid (mac_tvalid),
    .mac_axis_tlast  (mac_tlast),
    .mac_axis_tready (mac_tready),
    .busy            (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [8:0] exp_q[$];

  bit rnd_en     = 1'b0;
  bit gap_en     = 1'b0;
  bit arp_cnt_en = 1'b0;
  int arp_rdy_hi = 0;

  localparam logic [47:0] BCAST = 48'hffffffffffff;
  localparam logic [47:0] DST_A = 48'h0a1b2c3d4e5f;
  localparam logic [47:0] DST_B = 48'h665544332211;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] pay(input int seed, input int i);
    return 8'((seed * 37 + i * 11 + 5) & 255);
  endfunction

  // Expected frame: header, payload, zero pad up to 60 bytes, tlast on the end.
  // trunc >= 0 models a frame cut by reset after payload byte 'trunc'.
  task automatic push_frame(input logic [47:0] dst, input logic [15:0] et,
                            input int len, input int seed, input int trunc);
    logic [7:0]   b[$];
    logic [111:0] h;
    int           n;
    h = {dst, 48'h010203040506, et};
    for (int k = 0; k < 14; k++) b.push_back(h[111-8*k -: 8]);
    n = (trunc >= 0) ? trunc + 1 : len;
    for (int i = 0; i < n; i++) b.push_back(pay(seed, i));
    if (trunc < 0) while (b.size() < 60) b.push_back(8'h00);
    for (int k = 0; k < b.size(); k++)
      exp_q.push_back({(trunc < 0) && (k == b.size() - 1), b[k]});
  endtask

  task automatic set_src(input bit src, input bit v, input logic [7:0] d, input bit l);
    if (src) begin ip_tvalid = v; ip_tdata = d; ip_tlast = l; end
    else     begin arp_tvalid = v; arp_tdata = d; arp_tlast = l; end
  endtask

  // Source driver: src 0 = ARP, 1 = IPv4. Holds each byte until accepted.
  task automatic send(input bit src, input logic [47:0] dst, input int len,
                      input int seed, input bit gaps, input int trunc);
    bit acc;
    int w;
    int g;
    if (src) ip_dst = dst; else arp_dst = dst;
    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        repeat (g) begin set_src(src, 1'b0, 8'h00, 1'b0); @(posedge clk); #1; end
      end
      set_src(src, 1'b1, pay(seed, i), i == len - 1);
      if (i == trunc) return;
      acc = 1'b0;
      w = 0;
      while (!acc) begin
        @(negedge clk);
        acc = src ? ip_tready : arp_tready;
        @(posedge clk); #1;
        w++;
        if (!acc && w > 500) begin
          n_checks++;
          $display("FAIL src_timeout: src %0d byte %0d not accepted in 500 cycles", src, i);
          set_src(src, 1'b0, 8'h00, 1'b0);
          return;
        end
      end
    end
    set_src(src, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 400) begin @(posedge clk); w++; end
    repeat (3) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  // MAC-side ready: always 1 unless the random-stall phase is active.
  initial begin
    mac_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      mac_tready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare accepted bytes, held-data stability and inter-frame gap.
  initial begin
    logic [8:0] e;
    bit         prev_stall = 1'b0;
    logic [8:0] prev_out   = '0;
    bit         in_frame   = 1'b0;
    bit         have_last  = 1'b0;
    int         cyc        = 0;
    int         last_cyc   = 0;
    int         nbyte      = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (arp_cnt_en && arp_tready) arp_rdy_hi++;
      if (prev_stall && mac_tvalid) chk("stall_hold", {mac_tlast, mac_tdata}, prev_out);
      if (mac_tvalid && mac_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_byte: got %0h with nothing expected", {mac_tlast, mac_tdata});
        end else begin
          e = exp_q.pop_front();
          n_checks++;
          if ({mac_tlast, mac_tdata} === e) n_pass++;
          else $display("FAIL byte%0d: got last=%0b data=%02h expected last=%0b data=%02h",
                        nbyte, mac_tlast, mac_tdata, e[8], e[7:0]);
        end
        nbyte++;
        if (!in_frame) begin
          if (gap_en && have_last) chk("frame_gap", cyc - last_cyc, 2);
          in_frame = 1'b1;
        end
        if (mac_tlast) begin
          in_frame  = 1'b0;
          have_last = 1'b1;
          last_cyc  = cyc;
          $display("frame done: %0d bytes", nbyte);
          nbyte = 0;
        end
      end
      prev_stall = mac_tvalid && !mac_tready;
      prev_out   = {mac_tlast, mac_tdata};
      if (reset) begin in_frame = 1'b0; have_last = 1'b0; nbyte = 0; end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    arp_tvalid = 0; arp_tdata = 0; arp_tlast = 0; arp_dst = 0;
    ip_tvalid = 0;  ip_tdata = 0;  ip_tlast = 0;  ip_dst = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mac_tvalid", mac_tvalid, 0);
    chk("rst_mac_tlast",  mac_tlast, 0);
    chk("rst_mac_tdata",  mac_tdata, 0);
    chk("rst_arp_tready", arp_tready, 0);
    chk("rst_ip_tready",  ip_tready, 0);
    chk("rst_busy",       busy, 0);

    // Both sources request in the first cycle after reset, 3 frames each.
    reset = 1'b0;
    for (int f = 0; f < 3; f++) begin
      push_frame(DST_A, 16'h0806, 28, 10 + f, -1);
      push_frame(DST_B, 16'h0800, 50, 20 + f, -1);
    end
    gap_en = 1'b1;
    fork
      begin for (int f = 0; f < 3; f++) send(1'b0, DST_A, 28, 10 + f, 1'b0, -1); end
      begin for (int f = 0; f < 3; f++) send(1'b1, DST_B, 50, 20 + f, 1'b0, -1); end
    join
    drain("rr_drain");
    gap_en = 1'b0;

    // ARP 28-byte broadcast: padded to 60, one-cycle arbitration latency.
    push_frame(BCAST, 16'h0806, 28, 1, -1);
    fork
      send(1'b0, BCAST, 28, 1, 1'b0, -1);
      begin
        @(negedge clk); chk("arb_cycle_tvalid", mac_tvalid, 0);
        @(negedge clk); chk("hdr0_tvalid", mac_tvalid, 1);
        chk("hdr0_busy", busy, 1);
      end
    join
    drain("arp_drain");

    // IPv4 100-byte payload: no pad, ARP tready never asserted.
    push_frame(DST_B, 16'h0800, 100, 2, -1);
    arp_rdy_hi = 0;
    arp_cnt_en = 1'b1;
    send(1'b1, DST_B, 100, 2, 1'b0, -1);
    drain("ip100_drain");
    arp_cnt_en = 1'b0;
    chk("arp_tready_idle", arp_rdy_hi, 0);

    // IPv4 46-byte payload: exactly 60 bytes, tlast on last payload byte.
    push_frame(DST_A, 16'h0800, 46, 3, -1);
    send(1'b1, DST_A, 46, 3, 1'b0, -1);
    drain("ip46_drain");

    // Random MAC stalls and source gaps: 64-byte IPv4, then padded ARP.
    rnd_en = 1'b1;
    push_frame(DST_B, 16'h0800, 64, 4, -1);
    push_frame(DST_A, 16'h0806, 10, 5, -1);
    send(1'b1, DST_B, 64, 4, 1'b1, -1);
    send(1'b0, DST_A, 10, 5, 1'b1, -1);
    drain("stall_drain");
    rnd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset at ARP payload byte 20, then ARP must win against IPv4.
    push_frame(DST_A, 16'h0806, 40, 6, 20);
    send(1'b0, DST_A, 40, 6, 1'b0, 20);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("trunc_mac_tvalid", mac_tvalid, 0);
    chk("trunc_busy", busy, 0);
    chk("trunc_arp_tready", arp_tready, 0);
    set_src(1'b0, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    push_frame(DST_B, 16'h0806, 10, 7, -1);
    push_frame(DST_A, 16'h0800, 12, 8, -1);
    fork
      send(1'b0, DST_B, 10, 7, 1'b0, -1);
      send(1'b1, DST_A, 12, 8, 1'b0, -1);
    join
    drain("post_rst_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
